// File: rtl/wb_uart_pkg.sv
// Shared definitions for the UART-to-Wishbone command bridge:
// command/response byte codes and the bridge FSM encoding.
package wb_uart_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;
    localparam logic [7:0] RSP_ACK     = 8'h4B;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_BUS,
        ST_RESP
    } state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/wb_uart_bridge.sv
// Byte-stream command bridge: 'W' addr[4] data[4] / 'R' addr[4] commands from a UART
// become single Wishbone cycles; replies are 0x4B, 0xEE or four read bytes, MSB first.
module wb_uart_bridge
    import wb_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [3:0]  SEL     = 4'hF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i
);

    state_e      state, state_next;
    logic [1:0]  byte_cnt;
    logic [7:0]  tmo_cnt;
    logic [31:0] rdata;
    logic        is_write;
    logic        single_rsp;
    logic        tmo_hit;
    logic        tx_fire;
    logic        last_byte;

    assign stb_o     = cyc_o;
    assign sel_o     = SEL;
    assign tmo_hit   = (tmo_cnt == 8'(TIMEOUT - 1));
    assign tx_fire   = tx_valid && tx_ready;
    assign last_byte = single_rsp || (byte_cnt == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_IDLE:  if (rx_valid && is_cmd(rx_data)) state_next = ST_ADDR;
            ST_ADDR:  if (rx_valid && byte_cnt == 2'd3) state_next = is_write ? ST_WDATA : ST_BUS;
            ST_WDATA: if (rx_valid && byte_cnt == 2'd3) state_next = ST_BUS;
            ST_BUS:   if (ack_i || tmo_hit) state_next = ST_RESP;
            ST_RESP:  if (tx_fire && last_byte) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt   <= '0;
            tmo_cnt    <= '0;
            rdata      <= '0;
            is_write   <= 1'b0;
            single_rsp <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            we_o       <= 1'b0;
            cyc_o      <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            unique case (state)
                ST_IDLE: begin
                    if (rx_valid && is_cmd(rx_data)) begin
                        is_write <= (rx_data == CMD_WRITE);
                        byte_cnt <= '0;
                    end
                end
                // Address and data shift in MSB first; the counter wraps to 0 after byte 4.
                ST_ADDR: begin
                    if (rx_valid) begin
                        adr_o    <= {adr_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_WDATA: begin
                    if (rx_valid) begin
                        dat_o    <= {dat_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_BUS: begin
                    if (ack_i) begin
                        cyc_o      <= 1'b0;
                        we_o       <= 1'b0;
                        rdata      <= dat_i;
                        single_rsp <= is_write;
                        byte_cnt   <= '0;
                        tx_valid   <= 1'b1;
                        tx_data    <= is_write ? RSP_ACK : dat_i[31:24];
                    end else if (tmo_hit) begin
                        cyc_o      <= 1'b0;
                        we_o       <= 1'b0;
                        single_rsp <= 1'b1;
                        byte_cnt   <= '0;
                        tx_valid   <= 1'b1;
                        tx_data    <= RSP_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (tx_fire) begin
                        if (last_byte) begin
                            tx_valid <= 1'b0;
                        end else begin
                            tx_data  <= rdata[23:16];
                            rdata    <= {rdata[23:0], 8'h00};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase

            // Bus strobes rise on the same edge that enters BUS for single-cycle latency.
            if (state != ST_BUS && state_next == ST_BUS) begin
                cyc_o   <= 1'b1;
                we_o    <= is_write;
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_uart_bridge.sv
// Directed bench for wb_uart_bridge: write, read, timeout, ack-at-timeout,
// garbage byte with transmit backpressure, and asynchronous reset mid-cycle.
module tb_wb_uart_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [3:0]  sel_o;
    logic        ack_i;

    int tests_run = 0;
    int tests_failed = 0;

    wb_uart_bridge #(.TIMEOUT(255), .SEL(4'hF)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .adr_o    (adr_o),
        .dat_o    (dat_o),
        .dat_i    (dat_i),
        .we_o     (we_o),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .sel_o    (sel_o),
        .ack_i    (ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the byte is sampled by the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_i);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
    endtask

    task automatic recv(input string tag, input logic [7:0] exp, input int stall);
        int n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, " tx_valid"}, {31'd0, tx_valid}, 32'd1);
        tx_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            check({tag, " stalled"}, {24'd0, tx_data}, {24'd0, exp});
        end
        check(tag, {24'd0, tx_data}, {24'd0, exp});
        tx_ready = 1'b1;
        @(negedge clk_i);
        tx_ready = 1'b0;
    endtask

    task automatic ack_pulse(input logic [31:0] rd);
        dat_i = rd;
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        dat_i = 32'hDEAD_BEEF;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_ni   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        dat_i    = 32'h0;
        ack_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst cyc_o", {31'd0, cyc_o}, 32'd0);
        check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst adr_o", adr_o, 32'd0);
        check("sel_o", {28'd0, sel_o}, 32'hF);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Write 0x41 to 0x801, ack two cycles after strobe; a stray byte in BUS is dropped.
        send_cmd(8'h57, 32'h0000_0801);
        for (int i = 3; i >= 0; i--) send_byte(8'(32'h41 >> (i*8)));
        check("wr cyc_o", {31'd0, cyc_o}, 32'd1);
        check("wr stb_o", {31'd0, stb_o}, 32'd1);
        check("wr we_o", {31'd0, we_o}, 32'd1);
        check("wr adr_o", adr_o, 32'h0000_0801);
        check("wr dat_o", dat_o, 32'h0000_0041);
        send_byte(8'h52);
        check("wr hold cyc_o", {31'd0, cyc_o}, 32'd1);
        check("wr hold adr_o", adr_o, 32'h0000_0801);
        ack_pulse(32'h0);
        check("wr cyc_o after ack", {31'd0, cyc_o}, 32'd0);
        check("wr we_o after ack", {31'd0, we_o}, 32'd0);
        recv("wr rsp", 8'h4B, 0);
        check("wr tx_valid done", {31'd0, tx_valid}, 32'd0);

        // Read 0x800 returning 1.
        send_cmd(8'h52, 32'h0000_0800);
        check("rd cyc_o", {31'd0, cyc_o}, 32'd1);
        check("rd we_o", {31'd0, we_o}, 32'd0);
        check("rd adr_o", adr_o, 32'h0000_0800);
        ack_pulse(32'h0000_0001);
        check("rd cyc_o after ack", {31'd0, cyc_o}, 32'd0);
        recv("rd b0", 8'h00, 0);
        recv("rd b1", 8'h00, 0);
        recv("rd b2", 8'h00, 0);
        recv("rd b3", 8'h01, 0);
        check("rd tx_valid done", {31'd0, tx_valid}, 32'd0);

        // Timeout: strobe held exactly 255 cycles, reply 0xEE only.
        send_cmd(8'h52, 32'h0000_1234);
        cnt = 0;
        while (cyc_o && cnt < 300) begin
            cnt++;
            @(negedge clk_i);
        end
        check("tmo cycles", cnt, 32'd255);
        recv("tmo rsp", 8'hEE, 0);
        check("tmo single byte", {31'd0, tx_valid}, 32'd0);

        // Ack in the very cycle the counter would reach the limit: ack wins.
        send_cmd(8'h52, 32'h0000_0004);
        repeat (254) @(negedge clk_i);
        check("edge cyc_o", {31'd0, cyc_o}, 32'd1);
        ack_pulse(32'h1234_5678);
        recv("edge b0", 8'h12, 0);
        recv("edge b1", 8'h34, 0);
        recv("edge b2", 8'h56, 0);
        recv("edge b3", 8'h78, 0);
        check("edge tx_valid done", {31'd0, tx_valid}, 32'd0);

        // Garbage byte ignored; read reply under heavy backpressure.
        send_byte(8'h5A);
        repeat (3) @(negedge clk_i);
        check("garbage cyc_o", {31'd0, cyc_o}, 32'd0);
        check("garbage tx_valid", {31'd0, tx_valid}, 32'd0);
        send_cmd(8'h52, 32'h0000_0808);
        check("bp cyc_o", {31'd0, cyc_o}, 32'd1);
        check("bp adr_o", adr_o, 32'h0000_0808);
        ack_pulse(32'hA1B2_C3D4);
        recv("bp b0", 8'hA1, 10);
        recv("bp b1", 8'hB2, 10);
        recv("bp b2", 8'hC3, 10);
        recv("bp b3", 8'hD4, 10);
        check("bp tx_valid done", {31'd0, tx_valid}, 32'd0);

        // Asynchronous reset while the bus cycle is open.
        send_cmd(8'h57, 32'h0000_0020);
        for (int i = 0; i < 4; i++) send_byte(8'h11);
        check("rst pre cyc_o", {31'd0, cyc_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst cyc_o", {31'd0, cyc_o}, 32'd0);
        check("arst stb_o", {31'd0, stb_o}, 32'd0);
        check("arst we_o", {31'd0, we_o}, 32'd0);
        check("arst adr_o", adr_o, 32'd0);
        check("arst dat_o", dat_o, 32'd0);
        check("arst tx", {23'd0, tx_valid, tx_data}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post rst tx_valid", {31'd0, tx_valid}, 32'd0);
        send_cmd(8'h57, 32'h0000_0010);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hBA);
        send_byte(8'hBE);
        check("post rst cyc_o", {31'd0, cyc_o}, 32'd1);
        check("post rst adr_o", adr_o, 32'h0000_0010);
        check("post rst dat_o", dat_o, 32'hCAFE_BABE);
        ack_pulse(32'h0);
        recv("post rst rsp", 8'h4B, 0);
        check("post rst done", {31'd0, tx_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
